// File: rtl/pu_feeder.sv
// Purpose: gathers 4-word operand groups from memory and issues them to a processing unit, registering its results.
// Latency: 6 cycles per group (4 reads, 1 wait, 1 issue); result appears 3 cycles after issue; done 3 cycles after last issue.
// Backpressure: none; memory and processing unit are fixed-latency, start is ignored while a run is in progress.
module pu_feeder #(
    parameter int XLEN = 5,
    parameter int AW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic [AW-1:0]   group_cnt,
    output logic            mem_rd,
    output logic [AW-1:0]   mem_addr,
    input  logic [XLEN-1:0] mem_data,
    output logic [XLEN-1:0] num1,
    output logic [XLEN-1:0] num2,
    output logic [XLEN-1:0] num3,
    output logic [XLEN-1:0] num4,
    output logic            pu_issue,
    input  logic [XLEN-1:0] pu_result,
    output logic [XLEN-1:0] out_data,
    output logic            out_valid,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    logic [1:0]      k;          // word index inside a group; reused as drain counter
    logic [AW-1:0]   g;          // group index
    logic [AW-1:0]   base_q;
    logic [AW-1:0]   cnt_q;

    logic            rd_vld_q;   // a read was issued last cycle, data is on mem_data now
    logic [1:0]      rd_k_q;     // slot the returning word belongs to
    logic [XLEN-1:0] slot [4];
    logic [1:0]      vld_sr;     // issue tracker, bit 1 = result present on pu_result

    // Address arithmetic wraps modulo 2^AW by construction of the widths.
    logic [AW-1:0]   g_ofs;
    logic [AW-1:0]   g_nxt;
    logic [AW-1:0]   g_nxt_ofs;
    logic [AW-1:0]   fetch_nxt_addr;
    logic [AW-1:0]   group_nxt_addr;

    assign g_ofs          = g << 2;
    assign g_nxt          = g + AW'(1);
    assign g_nxt_ofs      = g_nxt << 2;
    assign fetch_nxt_addr = base_q + g_ofs + AW'(k) + AW'(1);
    assign group_nxt_addr = base_q + g_nxt_ofs;

    assign num1 = slot[0];
    assign num2 = slot[1];
    assign num3 = slot[2];
    assign num4 = slot[3];

    // Run sequencer: state, indices, latched run parameters and all control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            g        <= '0;
            base_q   <= '0;
            cnt_q    <= '0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            pu_issue <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            pu_issue <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (group_cnt != '0) begin
                            base_q   <= base_addr;
                            cnt_q    <= group_cnt;
                            k        <= '0;
                            g        <= '0;
                            mem_rd   <= 1'b1;
                            mem_addr <= base_addr;
                            state    <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                FETCH: begin
                    if (k == 2'd3) begin
                        k     <= '0;
                        state <= WAIT;
                    end else begin
                        k        <= k + 2'd1;
                        mem_rd   <= 1'b1;
                        mem_addr <= fetch_nxt_addr;
                    end
                end
                WAIT: begin
                    pu_issue <= 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    if (g_nxt < cnt_q) begin
                        g        <= g_nxt;
                        mem_rd   <= 1'b1;
                        mem_addr <= group_nxt_addr;
                        state    <= FETCH;
                    end else begin
                        k     <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (k == 2'd1) begin
                        k     <= '0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        k <= k + 2'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Remember which slot the outstanding read targets; data returns one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            rd_k_q   <= '0;
        end else begin
            rd_vld_q <= mem_rd;
            rd_k_q   <= k;
        end
    end

    // Capture returning memory words into their operand slots; slots hold between issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                slot[i] <= '0;
            end
        end else if (rd_vld_q) begin
            slot[rd_k_q] <= mem_data;
        end
    end

    // Track issues through the processing-unit latency and register its result.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            vld_sr    <= {vld_sr[0], pu_issue};
            out_valid <= vld_sr[1];
            if (vld_sr[1]) begin
                out_data <= pu_result;
            end
        end
    end

endmodule
